// File: rtl/cfg_loader_pkg.sv
// Shared types and helpers for the configuration latch sequencer.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } cfg_seq_state_t;

  localparam int CMD_CLR_ERR_BIT = 31;

  // Index width that never collapses to zero for single-entry vectors.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_prio_enc.sv
// Highest-set-bit encoder: idx is the top set bit of bits, valid when any is set.
module cfg_prio_enc #(
  parameter int N        = 8,
  parameter int IDX_BITS = 3
) (
  input  logic [N-1:0]        bits,
  output logic [IDX_BITS-1:0] idx,
  output logic                valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bits[i]) begin
        idx   = IDX_BITS'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_latch_sequencer.sv
// Stages a configuration word from bus writes, then pulses one latch enable
// per selected register, highest index first, with programmable pulse/gap.
module cfg_latch_sequencer
  import cfg_loader_pkg::*;
#(
  parameter int         NUM_REGS     = 8,
  parameter int         CFG_WIDTH    = 48,
  parameter logic [5:0] STAGE_BASE   = 6'h08,
  parameter logic [5:0] CMD_ADDR     = 6'h10,
  parameter int         PULSE_CYCLES = 1,
  parameter int         GAP_CYCLES   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_req,
  input  logic [5:0]           address,
  input  logic [31:0]          data_in,
  output logic [CFG_WIDTH-1:0] config_data,
  output logic [NUM_REGS-1:0]  latch_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output cfg_seq_state_t       state
);

  localparam int CFG_WORDS = (CFG_WIDTH + 31) / 32;
  localparam int IDX_BITS  = clog2_min1(NUM_REGS);
  localparam int WORD_BITS = clog2_min1(CFG_WORDS);
  localparam int CNT_MAX   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_BITS  = clog2_min1(CNT_MAX);

  // Handshake: write_req is a single-cycle strobe with no back-pressure;
  // writes arriving while busy are dropped and flagged through err.
  int                   stage_off;
  logic                 stage_hit;
  logic [WORD_BITS-1:0] stage_word;
  logic                 cmd_hit;
  logic                 accept_cmd;
  logic                 reject;
  logic [NUM_REGS-1:0]  mask;
  logic [NUM_REGS-1:0]  pending;
  logic [CNT_BITS-1:0]  cnt;
  logic [IDX_BITS-1:0]  enc_idx;
  logic                 enc_valid;

  assign stage_off = int'(address) - int'(STAGE_BASE);
  assign mask      = data_in[NUM_REGS-1:0];

  always_comb begin
    stage_hit  = 1'b0;
    stage_word = '0;
    cmd_hit    = write_req && (address == CMD_ADDR);
    if (write_req && stage_off >= 0 && stage_off[1:0] == 2'b00 &&
        (stage_off >>> 2) < CFG_WORDS) begin
      stage_hit  = 1'b1;
      stage_word = WORD_BITS'(stage_off >>> 2);
    end
  end

  assign accept_cmd = cmd_hit && !busy;
  assign reject     = (cmd_hit || stage_hit) && busy;

  cfg_prio_enc #(
    .N        (NUM_REGS),
    .IDX_BITS (IDX_BITS)
  ) u_prio_enc (
    .bits  (pending),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Bits beyond CFG_WIDTH in the last word simply have no storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      config_data <= '0;
    end else if (stage_hit && !busy) begin
      for (int i = 0; i < CFG_WIDTH; i++) begin
        if (int'(stage_word) == i / 32) config_data[i] <= data_in[i % 32];
      end
    end
  end

  // A rejection in the same cycle as a clear request leaves err set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (reject) begin
      err <= 1'b1;
    end else if (accept_cmd && data_in[CMD_CLR_ERR_BIT]) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      cnt      <= '0;
      latch_en <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_cmd) begin
            if (mask != '0) begin
              pending <= mask;
              busy    <= 1'b1;
              state   <= SETUP;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (enc_valid) begin
            latch_en <= NUM_REGS'(1) << enc_idx;
            cnt      <= CNT_BITS'(PULSE_CYCLES - 1);
            state    <= PULSE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            // The live enable is the one-hot of the target being served.
            pending  <= pending & ~latch_en;
            latch_en <= '0;
            cnt      <= CNT_BITS'(GAP_CYCLES - 1);
            state    <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (pending != '0) begin
              state <= SETUP;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_latch_sequencer.sv
// Directed bench: default instance plus a wide/slow instance, per-cycle expected waveforms.
module tb_cfg_latch_sequencer;
  import cfg_loader_pkg::*;

  logic clk;
  logic rst_n;

  logic        a_write_req, b_write_req;
  logic [5:0]  a_address, b_address;
  logic [31:0] a_data_in, b_data_in;
  logic [47:0] a_config_data;
  logic [71:0] b_config_data;
  logic [7:0]  a_latch_en;
  logic [19:0] b_latch_en;
  logic        a_busy, a_done, a_err, b_busy, b_done, b_err;
  cfg_seq_state_t a_state, b_state;

  int n_checks = 0;
  int n_errors = 0;
  int a_rises  = 0;
  logic [7:0] a_prev = '0;

  cfg_latch_sequencer u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_req   (a_write_req),
    .address     (a_address),
    .data_in     (a_data_in),
    .config_data (a_config_data),
    .latch_en    (a_latch_en),
    .busy        (a_busy),
    .done        (a_done),
    .err         (a_err),
    .state       (a_state)
  );

  cfg_latch_sequencer #(
    .NUM_REGS     (20),
    .CFG_WIDTH    (72),
    .STAGE_BASE   (6'h08),
    .CMD_ADDR     (6'h20),
    .PULSE_CYCLES (3),
    .GAP_CYCLES   (2)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_req   (b_write_req),
    .address     (b_address),
    .data_in     (b_data_in),
    .config_data (b_config_data),
    .latch_en    (b_latch_en),
    .busy        (b_busy),
    .done        (b_done),
    .err         (b_err),
    .state       (b_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    a_prev <= a_latch_en;
    if (a_latch_en != '0 && a_prev == '0) a_rises <= a_rises + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: one-cycle write strobe; returns at the negedge after the sampling edge.
  task automatic bus_write(input bit sel, input logic [5:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (sel) begin
      b_write_req = 1'b1; b_address = addr; b_data_in = data;
    end else begin
      a_write_req = 1'b1; a_address = addr; a_data_in = data;
    end
    @(negedge clk);
    a_write_req = 1'b0;
    b_write_req = 1'b0;
  endtask

  // Issues a command and checks latch_en/busy/done every cycle against a
  // waveform built from the mask: per target SETUP, P pulse cycles, G gap cycles.
  task automatic run_seq(input bit sel, input logic [31:0] mask, input int p, input int g,
                         input int nregs, input string name);
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic [31:0] one;
    logic [31:0] obs_en;
    logic        obs_busy, obs_done;
    int          c;
    int          busy_cnt;
    one = 32'd1;
    for (int t = nregs - 1; t >= 0; t--) begin
      if (mask[t]) begin
        exp_q.push_back({2'b01, 32'h0});
        for (int k = 0; k < p; k++) exp_q.push_back({2'b01, one << t});
        for (int k = 0; k < g; k++) exp_q.push_back({2'b01, 32'h0});
      end
    end
    exp_q.push_back({2'b10, 32'h0});
    exp_q.push_back({2'b00, 32'h0});
    bus_write(sel, sel ? 6'h20 : 6'h10, mask);
    c = 1;
    busy_cnt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      obs_en   = sel ? {12'h0, b_latch_en} : {24'h0, a_latch_en};
      obs_busy = sel ? b_busy : a_busy;
      obs_done = sel ? b_done : a_done;
      if (obs_busy) busy_cnt++;
      check_eq($sformatf("%s c%0d latch_en", name, c), obs_en, e[31:0]);
      check_eq($sformatf("%s c%0d busy", name, c), obs_busy, e[32]);
      check_eq($sformatf("%s c%0d done", name, c), obs_done, e[33]);
      c++;
      @(negedge clk);
    end
    check_eq({name, " busy_len"}, busy_cnt, $countones(mask[19:0]) * (p + 1 + g));
  endtask

  initial begin
    int r0;
    rst_n = 1'b0;
    a_write_req = 1'b0; a_address = '0; a_data_in = '0;
    b_write_req = 1'b0; b_address = '0; b_data_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst config_data", a_config_data, 48'h0);
    check_eq("rst latch_en", a_latch_en, 8'h0);
    check_eq("rst busy_done_err", {a_busy, a_done, a_err}, 3'b000);
    check_eq("rst state", a_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep
    bus_write(1'b0, 6'h08, 32'h89ABCDEF);
    bus_write(1'b0, 6'h0C, 32'h00001234);
    check_eq("sweep config_data", a_config_data, 48'h123489ABCDEF);
    run_seq(1'b0, 32'h000000FF, 1, 1, 8, "sweep");

    // Sparse, zero mask
    run_seq(1'b0, 32'h00000024, 1, 1, 8, "sparse");
    run_seq(1'b0, 32'h00000000, 1, 1, 8, "zero");

    // Unmapped writes are silent
    bus_write(1'b0, 6'h3C, 32'hFFFFFFFF);
    bus_write(1'b0, 6'h04, 32'hFFFFFFFF);
    check_eq("unmapped err", a_err, 1'b0);
    check_eq("unmapped config", a_config_data, 48'h123489ABCDEF);
    check_eq("unmapped busy", a_busy, 1'b0);

    // Protocol error: rejected stage write and rejected command (with clear bit)
    @(negedge clk);
    r0 = a_rises;
    bus_write(1'b0, 6'h10, 32'h000000FF);
    repeat (3) @(negedge clk);
    bus_write(1'b0, 6'h08, 32'hDEADBEEF);
    check_eq("perr err_set", a_err, 1'b1);
    check_eq("perr still_busy", a_busy, 1'b1);
    bus_write(1'b0, 6'h10, 32'h800000FF);
    check_eq("perr set_wins", a_err, 1'b1);
    for (int i = 0; i < 100 && a_busy; i++) @(negedge clk);
    check_eq("perr busy_drop", a_busy, 1'b0);
    check_eq("perr done", a_done, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("perr pulse_count", a_rises - r0, 8);
    check_eq("perr config_frozen", a_config_data, 48'h123489ABCDEF);
    check_eq("perr err_sticky", a_err, 1'b1);
    r0 = a_rises;
    bus_write(1'b0, 6'h10, 32'h80000000);
    check_eq("clr err", a_err, 1'b0);
    check_eq("clr done", a_done, 1'b1);
    check_eq("clr busy", a_busy, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("clr no_pulse", a_rises - r0, 0);

    // Wide instance: truncated last word, 3-cycle pulses, 2-cycle gaps
    bus_write(1'b1, 6'h08, 32'h11223344);
    bus_write(1'b1, 6'h0C, 32'h55667788);
    bus_write(1'b1, 6'h10, 32'hAABBCCDD);
    check_eq("wide config_data", b_config_data, 72'hDD_55667788_11223344);
    run_seq(1'b1, 32'h00080001, 3, 2, 20, "wide");
    check_eq("wide err", b_err, 1'b0);

    // Reset while latch_en[6] is high
    bus_write(1'b0, 6'h10, 32'h000000FF);
    for (int i = 0; i < 50 && a_latch_en[6] !== 1'b1; i++) @(negedge clk);
    check_eq("rst_mid reached_bit6", a_latch_en[6], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid latch_en", a_latch_en, 8'h0);
    check_eq("rst_mid busy_done_err", {a_busy, a_done, a_err}, 3'b000);
    check_eq("rst_mid config_data", a_config_data, 48'h0);
    check_eq("rst_mid state", a_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_mid idle_after", {a_busy, a_latch_en}, 9'h0);
    run_seq(1'b0, 32'h00000041, 1, 1, 8, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
